// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback FIFO serialising ALU and load results onto one register-file write port
//
// Purpose:
//   Collects up to two register results per cycle (load path, then ALU path),
//   queues them in program order and issues one registered write per cycle.
//   Producers are throttled through stall; a lost push raises a sticky overflow.
//
// Optional feature:
//   WRITEBACK_FORWARD_EN - when defined, pending writes are searched
//   combinationally so the read side can bypass the register file.
//   Undefined builds tie fwdHit1/fwdHit2 and fwdData1/fwdData2 to 0.
//
// Ports:
//   clock, reset                     clock; asynchronous active-high reset
//   memValid/memReg/memData          load result (older instruction)
//   aluValid/aluReg/aluData          ALU result (younger instruction)
//   stall                            fewer than 2 free slots
//   overflow                         sticky: a push was dropped
//   regWrite/writeRegister/writeData registered register-file write port
//   register1/register2              read indices to search
//   fwdHit1/fwdData1, fwdHit2/fwdData2  newest pending value per read index

module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memValid,
  input  logic [REG_WIDTH-1:0]  memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  aluValid,
  input  logic [REG_WIDTH-1:0]  aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  stall,
  output logic                  overflow,
  output logic                  regWrite,
  output logic [REG_WIDTH-1:0]  writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [REG_WIDTH-1:0]  register1,
  input  logic [REG_WIDTH-1:0]  register2,
  output logic                  fwdHit1,
  output logic [DATA_WIDTH-1:0] fwdData1,
  output logic                  fwdHit2,
  output logic [DATA_WIDTH-1:0] fwdData2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [REG_WIDTH-1:0]  ent_reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_WIDTH-1:0]  write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic                  pop;
  logic                  mem_push, alu_push;
  logic                  mem_ok, alu_ok;
  logic [CNT_W-1:0]      free_slots;
  logic [PTR_W-1:0]      alu_slot;

  // Writes to register 0 are architecturally void, so they never take a slot.
  assign mem_push = memValid && (memReg != '0);
  assign alu_push = aluValid && (aluReg != '0);

  assign pop = (count_q != '0);

  // The slot freed by this cycle's pop is available to this cycle's pushes.
  assign free_slots = DEPTH_C - count_q + {{(CNT_W-1){1'b0}}, pop};

  // The load result belongs to the older instruction and is placed first.
  assign mem_ok   = mem_push && (free_slots != '0);
  assign alu_ok   = alu_push && (mem_ok ? (free_slots >= CNT_W'(2)) : (free_slots != '0));
  assign alu_slot = mem_ok ? (tail_q + PTR_W'(1)) : tail_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = ent_reg_q[head_q];
      write_data_d = ent_data_q[head_q];
      head_d       = head_q + PTR_W'(1);
    end

    tail_d  = tail_q + PTR_W'(mem_ok) + PTR_W'(alu_ok);
    count_d = count_q + CNT_W'(mem_ok) + CNT_W'(alu_ok) - CNT_W'(pop);

    if ((mem_push && !mem_ok) || (alu_push && !alu_ok)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by head/count only.
  always_ff @(posedge clock) begin
    if (mem_ok) begin
      ent_reg_q[tail_q]  <= memReg;
      ent_data_q[tail_q] <= memData;
    end
    if (alu_ok) begin
      ent_reg_q[alu_slot]  <= aluReg;
      ent_data_q[alu_slot] <= aluData;
    end
  end

  assign stall         = !reset && ((DEPTH_C - count_q) < CNT_W'(2));
  assign overflow      = overflow_q;
  assign regWrite      = reg_write_q;
  assign writeRegister = write_reg_q;
  assign writeData     = write_data_q;

`ifdef WRITEBACK_FORWARD_EN
  // Search oldest to newest so later matches overwrite earlier ones: the
  // output register is oldest, then FIFO head through tail.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwdHit1  = 1'b0;
    fwdData1 = '0;
    fwdHit2  = 1'b0;
    fwdData2 = '0;
    idx      = '0;
    if (!reset) begin
      if (reg_write_q && (write_reg_q == register1)) begin
        fwdHit1  = 1'b1;
        fwdData1 = write_data_q;
      end
      if (reg_write_q && (write_reg_q == register2)) begin
        fwdHit2  = 1'b1;
        fwdData2 = write_data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if (CNT_W'(k) < count_q) begin
          if (ent_reg_q[idx] == register1) begin
            fwdHit1  = 1'b1;
            fwdData1 = ent_data_q[idx];
          end
          if (ent_reg_q[idx] == register2) begin
            fwdHit2  = 1'b1;
            fwdData2 = ent_data_q[idx];
          end
        end
      end
      // Register 0 is never pending; its reads always come from the file.
      if (register1 == '0) begin
        fwdHit1  = 1'b0;
        fwdData1 = '0;
      end
      if (register2 == '0) begin
        fwdHit2  = 1'b0;
        fwdData2 = '0;
      end
    end
  end
`else
  logic unused_read_idx;
  assign unused_read_idx = ^{register1, register2};
  assign fwdHit1  = 1'b0;
  assign fwdData1 = '0;
  assign fwdHit2  = 1'b0;
  assign fwdData2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue

module tb_writeback_queue;

`ifdef WRITEBACK_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        memValid, aluValid;
  logic [4:0]  memReg, aluReg;
  logic [31:0] memData, aluData;
  logic        stall, overflow, regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  register1, register2;
  logic        fwdHit1, fwdHit2;
  logic [31:0] fwdData1, fwdData2;

  int n_checks = 0;
  int n_errors = 0;

  writeback_queue #(.DEPTH(4), .DATA_WIDTH(32), .REG_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .memValid(memValid), .memReg(memReg), .memData(memData),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData),
    .stall(stall), .overflow(overflow),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .register1(register1), .register2(register2),
    .fwdHit1(fwdHit1), .fwdData1(fwdData1),
    .fwdHit2(fwdHit2), .fwdData2(fwdData2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    memValid = mv; memReg = mr; memData = md;
    aluValid = av; aluReg = ar; aluData = ad;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Expect a committed write (or none) after the edge just taken.
  task automatic expect_wr(input string tag, input logic rw, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".rw"}, {31'b0, regWrite}, {31'b0, rw});
    if (rw) begin
      check({tag, ".reg"}, {27'b0, writeRegister}, {27'b0, r});
      check({tag, ".data"}, writeData, d);
    end
  endtask

  // Back-pressure vectors: four dual pushes, the last alu push is dropped.
  logic [4:0]  bp_mr [4] = '{5'd1, 5'd3, 5'd5, 5'd8};
  logic [31:0] bp_md [4] = '{32'hA1, 32'hB1, 32'hC1, 32'hD1};
  logic [4:0]  bp_ar [4] = '{5'd2, 5'd4, 5'd6, 5'd10};
  logic [31:0] bp_ad [4] = '{32'hA2, 32'hB2, 32'hC2, 32'hD2};
  // Expected after each of those four edges.
  logic        bp_rw [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0]  bp_wr [4] = '{5'd0, 5'd1, 5'd2, 5'd3};
  logic [31:0] bp_wd [4] = '{32'h0, 32'hA1, 32'hA2, 32'hB1};
  logic        bp_st [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic        bp_ov [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  // Drain after inputs go idle.
  logic [4:0]  dr_wr [4] = '{5'd4, 5'd5, 5'd6, 5'd8};
  logic [31:0] dr_wd [4] = '{32'hB2, 32'hC1, 32'hC2, 32'hD1};
  logic        dr_st [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1;
    idle();
    register1 = 5'd0;
    register2 = 5'd0;
    tick();
    tick();
    check("rst.rw", {31'b0, regWrite}, 32'd0);
    check("rst.stall", {31'b0, stall}, 32'd0);
    check("rst.ovf", {31'b0, overflow}, 32'd0);
    check("rst.hit1", {31'b0, fwdHit1}, 32'd0);
    check("rst.data1", fwdData1, 32'd0);
    reset = 1'b0;
    tick();

    // Single push: two edges to commit.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA);
    tick();
    idle();
    expect_wr("single.n", 1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("single.n1", 1'b1, 5'd5, 32'hAA);
    tick();
    expect_wr("single.n2", 1'b0, 5'd0, 32'h0);
    check("single.hold", {27'b0, writeRegister}, 32'd5);

    // Dual push to same register: mem first.
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    tick();
    idle();
    tick();
    expect_wr("dual.0", 1'b1, 5'd3, 32'h11);
    tick();
    expect_wr("dual.1", 1'b1, 5'd3, 32'h22);
    tick();
    expect_wr("dual.2", 1'b0, 5'd0, 32'h0);

    // Register zero filtered.
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77);
    tick();
    idle();
    check("zero.stall", {31'b0, stall}, 32'd0);
    tick();
    expect_wr("zero.0", 1'b1, 5'd7, 32'h77);
    tick();
    expect_wr("zero.1", 1'b0, 5'd0, 32'h0);

    // Back-pressure and overflow.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bp_mr[i], bp_md[i], 1'b1, bp_ar[i], bp_ad[i]);
      tick();
      expect_wr($sformatf("bp.%0d", i), bp_rw[i], bp_wr[i], bp_wd[i]);
      check($sformatf("bp.%0d.stall", i), {31'b0, stall}, {31'b0, bp_st[i]});
      check($sformatf("bp.%0d.ovf", i), {31'b0, overflow}, {31'b0, bp_ov[i]});
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_wr($sformatf("drain.%0d", i), 1'b1, dr_wr[i], dr_wd[i]);
      check($sformatf("drain.%0d.stall", i), {31'b0, stall}, {31'b0, dr_st[i]});
    end
    tick();
    expect_wr("drain.end", 1'b0, 5'd0, 32'h0);
    check("drain.ovf_sticky", {31'b0, overflow}, 32'd1);

    // Forwarding: 9<-1 then 9<-2.
    register1 = 5'd9;
    register2 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1);
    tick();
    check("fwd.0.hit1", {31'b0, fwdHit1}, {31'b0, FWD});
    check("fwd.0.data1", fwdData1, FWD ? 32'h1 : 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h2);
    tick();
    idle();
    check("fwd.1.hit1", {31'b0, fwdHit1}, {31'b0, FWD});
    check("fwd.1.data1", fwdData1, FWD ? 32'h2 : 32'h0);
    check("fwd.1.hit2", {31'b0, fwdHit2}, 32'd0);
    tick();
    expect_wr("fwd.2", 1'b1, 5'd9, 32'h2);
    check("fwd.2.hit1", {31'b0, fwdHit1}, {31'b0, FWD});
    check("fwd.2.data1", fwdData1, FWD ? 32'h2 : 32'h0);
    check("fwd.2.hit2", {31'b0, fwdHit2}, 32'd0);
    tick();
    check("fwd.3.hit1", {31'b0, fwdHit1}, 32'd0);
    check("fwd.3.hit2", {31'b0, fwdHit2}, 32'd0);

    // Mid-stream reset, asserted between edges.
    drive(1'b1, 5'd11, 32'h111, 1'b1, 5'd12, 32'h222);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h333);
    tick();
    idle();
    expect_wr("mid.pre", 1'b1, 5'd11, 32'h111);
    #2;
    reset = 1'b1;
    #1;
    check("mid.async.rw", {31'b0, regWrite}, 32'd0);
    check("mid.async.stall", {31'b0, stall}, 32'd0);
    check("mid.async.ovf", {31'b0, overflow}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid.post.%0d.rw", i), {31'b0, regWrite}, 32'd0);
      check($sformatf("mid.post.%0d.stall", i), {31'b0, stall}, 32'd0);
    end
    check("mid.post.ovf", {31'b0, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side counterpart of the register file: collects register results from the ALU path and the load path and serialises them onto the register file's single write port (`regWrite`, `writeRegister`, `writeData`).
- Buffers simultaneous results in a small in-order FIFO.
- Back-pressures the pipeline through `stall`.
- Optionally forwards pending (not yet written) values to the read side.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 32, width of register data.
- REG_WIDTH, 5, width of a register index.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- memValid  input  1  load result present this cycle.
- memReg  input  REG_WIDTH  destination register of the load result.
- memData  input  DATA_WIDTH  load result data.
- aluValid  input  1  ALU result present this cycle.
- aluReg  input  REG_WIDTH  destination register of the ALU result.
- aluData  input  DATA_WIDTH  ALU result data.
- stall  output  1  high when fewer than 2 free FIFO slots remain; producers must hold off.
- overflow  output  1  sticky error: a push was lost.
- regWrite  output  1  write enable to the register file (registered).
- writeRegister  output  REG_WIDTH  write index to the register file (registered).
- writeData  output  DATA_WIDTH  write data to the register file (registered).
- register1  input  REG_WIDTH  read index 1, same as the register file's port.
- register2  input  REG_WIDTH  read index 2.
- fwdHit1  output  1  a pending write to `register1` exists.
- fwdData1  output  DATA_WIDTH  newest pending value for `register1`.
- fwdHit2  output  1  as `fwdHit1`, for `register2`.
- fwdData2  output  DATA_WIDTH  as `fwdData1`, for `register2`.

Behaviour:
- Reset (async, active-high) clears:
  - FIFO pointers, count, `regWrite`, `writeRegister`, `writeData`, `overflow`.
  - While reset is held: `stall` = 0, `fwdHit1`/`fwdHit2` = 0, `fwdData1`/`fwdData2` = 0.
  - Entries in flight when reset asserts are discarded; no partial write is issued.
- Push filter: a valid input whose register index is 0 is discarded and never occupies a slot.
- Push ordering: if both inputs are valid in the same cycle, the mem entry is enqueued first (it belongs to the older instruction), then the alu entry. Up to 2 pushes per cycle.
- Pop: each cycle in which the FIFO is non-empty at the clock edge, the head is popped into the output registers with `regWrite` = 1. Otherwise `regWrite` = 0; `writeRegister`/`writeData` hold their last values.
- Latency: a result pushed at edge N into an empty FIFO appears on `regWrite`/`writeRegister`/`writeData` during cycle N+1 → 2 edges from input to the register file commit.
- Pop and push in the same cycle are permitted. Count update: count_next = count + pushes − pop.
- `stall` is combinational from the registered count: `stall` = (DEPTH − count < 2). Pops in the current cycle are not credited.
- Overflow: a push that finds no free slot (after that cycle's pop) is dropped and sets `overflow`. `overflow` stays 1 until reset. The other, fitting push of that cycle is kept.
- Pointers wrap modulo DEPTH.
- Output order equals enqueue order, so writes to the same register commit oldest to newest.

Optional Feature:
- Macro: WRITEBACK_FORWARD_EN.
- Defined: `fwdHitN` = 1 when `registerN` ≠ 0 and matches any valid FIFO entry or the output register while `regWrite` = 1. `fwdDataN` = the newest match, with priority from FIFO tail, through FIFO head, to the output register. Combinational; same-cycle inputs are not searched.
- Not defined: `fwdHit1`/`fwdHit2` are tied to 0 and `fwdData1`/`fwdData2` to 0; no search logic is generated.

Test Plan:
- Reset mid-stream: push 3 entries, assert reset for 1 cycle → no `regWrite` follows; count 0; `stall` 0; `overflow` 0.
- Single push: aluValid, aluReg=5, aluData=32'h0000_00AA → cycle N+1: `regWrite`=1, `writeRegister`=5, `writeData`=32'hAA; next cycle `regWrite`=0.
- Dual push: memReg=3/memData=32'h11 and aluReg=3/aluData=32'h22 in the same cycle → writes issued on consecutive cycles: 3←32'h11, then 3←32'h22.
- Register zero: memValid with memReg=0 and aluValid with aluReg=7 → only the write to 7 is issued; count peaks at 1.
- Back-pressure (DEPTH=4): dual pushes for 2 consecutive cycles → `stall`=1 once count ≥ 3. A further dual push while full sets `overflow`=1; all 4 queued writes still drain in order.
- Forwarding (WRITEBACK_FORWARD_EN): queue 9←32'h1, then 9←32'h2; `register1`=9 → `fwdHit1`=1 and `fwdData1`=32'h2 until the last write to 9 leaves the output register. `register2`=0 → `fwdHit2`=0 throughout.
